// File: rtl/spi_packet_rx.sv
// SPI mode-0 slave receiver: synchronizes SCLK/CS/MOSI into i_clk_10 and assembles PACKET_BITS words, echoing the last word on MISO.
// Latency: packet pulse one cycle after the final synchronized SCLK rising strobe; no backpressure (master paces all traffic).
module spi_packet_rx #(
  parameter int PACKET_BITS = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   i_clk_10,
  input  logic                   i_rst_n,
  input  logic                   i_spi_sclk,
  input  logic                   i_spi_cs_n,
  input  logic                   i_spi_mosi,
  output logic                   o_spi_miso,
  output logic                   o_spi_packet_rec,
  output logic [PACKET_BITS-1:0] o_packet_data,
  output logic                   o_frame_err
);

  localparam int CW = $clog2(PACKET_BITS + 1);
  localparam logic [CW-1:0] LAST = CW'(PACKET_BITS - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync, settle;
  logic                   sclk_d;
  logic                   sclk_s, cs_s, mosi_s, ready;
  logic                   rise, fall, done;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [PACKET_BITS-1:0] rx_sr, miso_sr, rx_next;
  logic                   armed;

  always_ff @(posedge i_clk_10 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      settle    <= '0;
      sclk_d    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_spi_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
      settle    <= {settle[SYNC_STAGES-2:0], 1'b1};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s  = sclk_sync[SYNC_STAGES-1];
  assign cs_s    = cs_sync[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync[SYNC_STAGES-1];
  // CS chain resets high, so a "high" is only trusted once real input has flushed the chain.
  assign ready   = settle[SYNC_STAGES-1];
  assign rise    = sclk_s & ~sclk_d;
  assign fall    = ~sclk_s & sclk_d;
  assign rx_next = {rx_sr[PACKET_BITS-2:0], mosi_s};
  assign done    = rise && (cnt == LAST);

  assign o_spi_miso = miso_sr[PACKET_BITS-1];

  always_ff @(posedge i_clk_10 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state            <= IDLE;
      cnt              <= '0;
      rx_sr            <= '0;
      miso_sr          <= '0;
      armed            <= 1'b0;
      o_packet_data    <= '0;
      o_spi_packet_rec <= 1'b0;
      o_frame_err      <= 1'b0;
    end else begin
      o_spi_packet_rec <= 1'b0;
      o_frame_err      <= 1'b0;
      case (state)
        IDLE: begin
          if (ready && cs_s) armed <= 1'b1;
          if (armed && !cs_s) begin
            state   <= ACTIVE;
            cnt     <= '0;
            miso_sr <= o_packet_data;
          end
        end
        ACTIVE: begin
          if (done) begin
            rx_sr            <= rx_next;
            o_packet_data    <= rx_next;
            miso_sr          <= rx_next;
            o_spi_packet_rec <= 1'b1;
            cnt              <= '0;
          end else if (cs_s) begin
            o_frame_err <= (cnt != '0);
            cnt         <= '0;
          end else if (rise) begin
            rx_sr <= rx_next;
            cnt   <= cnt + CW'(1);
          end else if (fall && cnt != '0) begin
            // A fall with cnt==0 closes the word that just reloaded MISO; keep its MSB for the next word.
            miso_sr <= miso_sr << 1;
          end
          if (cs_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
